// File: rtl/systolic_arbiter.sv
// Two-requester round-robin front end for a 4x4 int8 systolic array.
// Accepts one job at a time, launches it on the array, waits for completion
// (or a timeout) and presents the result with a valid/ready handshake.
module systolic_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_a,
  input  logic [127:0] req0_b,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_a,
  input  logic [127:0] req1_b,

  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic         resp_error,
  output logic [511:0] resp_y,

  output logic         sa_valid_in,
  output logic [127:0] sa_matrix_A,
  output logic [127:0] sa_matrix_B,
  input  logic [511:0] sa_y,
  input  logic         sa_done,

  output logic         busy,
  output logic [15:0]  jobs_done
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LastWait = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] wait_cnt;
  logic          grant0;
  logic          grant1;
  logic          idle;

  // Round-robin grant; ready only in IDLE and never while reset is held.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    idle       = (state == StIdle) & ~reset;
    req0_ready = idle & grant0;
    req1_ready = idle & grant1;
    busy       = (state != StIdle);
  end

  // Job sequencer with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      last_grant  <= 1'b1;
      wait_cnt    <= '0;
      jobs_done   <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_error  <= 1'b0;
      resp_y      <= '0;
      sa_valid_in <= 1'b0;
      sa_matrix_A <= '0;
      sa_matrix_B <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (grant0) begin
            sa_matrix_A <= req0_a;
            sa_matrix_B <= req0_b;
            resp_id     <= 1'b0;
            last_grant  <= 1'b0;
            sa_valid_in <= 1'b1;
            state       <= StIssue;
          end else if (grant1) begin
            sa_matrix_A <= req1_a;
            sa_matrix_B <= req1_b;
            resp_id     <= 1'b1;
            last_grant  <= 1'b1;
            sa_valid_in <= 1'b1;
            state       <= StIssue;
          end
        end
        StIssue: begin
          sa_valid_in <= 1'b0;
          wait_cnt    <= '0;
          state       <= StWait;
        end
        StWait: begin
          wait_cnt <= wait_cnt + CW'(1);
          // done is still high from the previous job in the first WAIT cycle
          if ((wait_cnt != '0) && sa_done) begin
            resp_y     <= sa_y;
            resp_error <= 1'b0;
            resp_valid <= 1'b1;
            if (jobs_done != 16'hFFFF) begin
              jobs_done <= jobs_done + 16'd1;
            end
            state <= StResp;
          end else if (wait_cnt == LastWait) begin
            resp_y     <= '0;
            resp_error <= 1'b1;
            resp_valid <= 1'b1;
            state      <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_arbiter.sv
// Directed self-checking bench for systolic_arbiter; the bench plays the array.
module tb_systolic_arbiter;

  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp_valid, resp_ready, resp_id, resp_error;
  logic [511:0] resp_y;
  logic         sa_valid_in;
  logic [127:0] sa_matrix_A, sa_matrix_B;
  logic [511:0] sa_y;
  logic         sa_done;
  logic         busy;
  logic [15:0]  jobs_done;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_jobs = 0;

  localparam logic [127:0] Ident = 128'h01000000_00010000_00000100_00000001;
  localparam logic [127:0] AllTwo = {16{8'h02}};

  systolic_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_error (resp_error),
    .resp_y     (resp_y),
    .sa_valid_in(sa_valid_in),
    .sa_matrix_A(sa_matrix_A),
    .sa_matrix_B(sa_matrix_B),
    .sa_y       (sa_y),
    .sa_done    (sa_done),
    .busy       (busy),
    .jobs_done  (jobs_done)
  );

  always #5 clk = ~clk;

  // Count start pulses seen by the array.
  always @(posedge clk) begin
    if (sa_valid_in) pulses <= pulses + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_error"}, resp_error, 0);
    chk({tag, "_resp_id"}, resp_id, 0);
    chk({tag, "_resp_y"}, resp_y, 0);
    chk({tag, "_sa_valid_in"}, sa_valid_in, 0);
    chk({tag, "_sa_A"}, sa_matrix_A, 0);
    chk({tag, "_sa_B"}, sa_matrix_B, 0);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_jobs"}, jobs_done, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_zero("rst");
    tick();
    reset = 1'b0;
    exp_jobs = 0;
  endtask

  // One job: present valids, expect grant to id, array finishes in WAIT cycle k
  // (never when tmo), hold resp_ready low for bp cycles, then handshake.
  task automatic do_job(input logic v0, input logic v1, input logic id, input int k,
                        input logic stale, input int bp, input logic [511:0] y,
                        input logic tmo);
    logic [127:0] ea, eb;
    logic [511:0] ey;
    int p0;
    ea = id ? req1_a : req0_a;
    eb = id ? req1_b : req0_b;
    ey = tmo ? 512'd0 : y;
    p0 = pulses;
    req0_valid = v0;
    req1_valid = v1;
    #1;
    chk("grant0", req0_ready, (id == 1'b0));
    chk("grant1", req1_ready, (id == 1'b1));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("issue_pulse", sa_valid_in, 1);
    chk("issue_A", sa_matrix_A, ea);
    chk("issue_B", sa_matrix_B, eb);
    chk("issue_busy", busy, 1);
    chk("issue_ready0", req0_ready, 0);
    sa_done = stale;
    sa_y = {16{32'hDEAD_BEEF}};
    for (int j = 1; j <= k; j++) begin
      tick();
      if (j == 1) chk("pulse_end", sa_valid_in, 0);
      chk("early_resp", resp_valid, 0);
      sa_done = !tmo && ((j == k) || (stale && j == 1));
      if (j == k && !tmo) sa_y = y;
    end
    tick();
    sa_done = 1'b0;
    if (!tmo) exp_jobs++;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, id);
    chk("resp_error", resp_error, tmo);
    chk("resp_y", resp_y, ey);
    chk("jobs_done", jobs_done, exp_jobs);
    chk("one_pulse", pulses - p0, 1);
    for (int d = 0; d < bp; d++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      tick();
      chk("bp_valid", resp_valid, 1);
      chk("bp_y", resp_y, ey);
      chk("bp_id", resp_id, id);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("post_valid", resp_valid, 0);
    chk("post_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = Ident;
    req0_b = AllTwo;
    req1_a = 128'h0;
    req1_b = 128'h0;
    resp_ready = 1'b0;
    sa_y = '0;
    sa_done = 1'b0;
    tick();
    tick();
    chk_zero("init");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;

    // Single identity job on req0.
    do_job(1'b1, 1'b0, 1'b0, 2, 1'b0, 0, {16{32'd2}}, 1'b0);

    // Contention from reset: grants alternate starting with req0.
    do_reset();
    req0_a = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    req0_b = 128'h0101_0101_0101_0101_0101_0101_0101_0101;
    req1_a = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    req1_b = 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0;
    for (int n = 0; n < 6; n++) begin
      do_job(1'b1, 1'b1, n[0], 2 + n, 1'b0, 0, {16{32'h100 + n}}, 1'b0);
    end

    // Backpressure for 10 cycles.
    do_job(1'b1, 1'b0, 1'b0, 3, 1'b0, 10, {16{32'hCAFE_0001}}, 1'b0);

    // Timeout on req1: error, zero result, count unchanged.
    do_job(1'b0, 1'b1, 1'b1, TO, 1'b0, 0, '0, 1'b1);

    // Stale done through ISSUE and first WAIT cycle.
    do_job(1'b1, 1'b0, 1'b0, 2, 1'b1, 0, {16{32'h5A5A_0002}}, 1'b0);

    // Completion in the very cycle the timeout would fire.
    do_job(1'b0, 1'b1, 1'b1, TO, 1'b0, 0, {16{32'h0000_0808}}, 1'b0);

    // Valid withdrawn without handshake: no state change.
    req1_valid = 1'b1;
    #1;
    chk("withdraw_ready", req1_ready, 1);
    req1_valid = 1'b0;
    tick();
    chk("withdraw_busy", busy, 0);
    chk("withdraw_pulse", sa_valid_in, 0);

    // Reset while in WAIT, then a fresh req1 job.
    req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    chk("wait_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk_zero("midjob");
    tick();
    tick();
    chk_zero("midjob_hold");
    reset = 1'b0;
    exp_jobs = 0;
    req1_a = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    req1_b = 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210;
    do_job(1'b0, 1'b1, 1'b1, 3, 1'b0, 0, {16{32'hBEEF_0045}}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_arbiter.md
SYSTOLIC_ARBITER -- requirements
Module: systolic_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum number of WAIT cycles allowed before a job is aborted with an error.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  SHALL each indicate that requester N presents a job.
REQ-005 req0_ready / req1_ready  out  1  SHALL each indicate that the arbiter accepts requester N's job this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  in  128  SHALL carry the signed 8-bit 4x4 operand matrices, row-major, with element [0][0] in bits [127:120].
REQ-007 resp_valid  out  1  SHALL indicate that a result is presented.
REQ-008 resp_ready  in  1  SHALL indicate that the consumer accepts the result.
REQ-009 resp_id  out  1  SHALL identify the requester that owns the result.
REQ-010 resp_error  out  1  SHALL flag a timed-out job.
REQ-011 resp_y  out  512  SHALL carry sixteen signed 32-bit results, with y[0][0] in bits [511:480].
REQ-012 sa_valid_in  out  1  SHALL be the start pulse to the array.
REQ-013 sa_matrix_A / sa_matrix_B  out  128  SHALL carry the operands to the array.
REQ-014 sa_y  in  512  SHALL carry the array result.
REQ-015 sa_done  in  1  SHALL be the array's completion flag.
REQ-016 busy  out  1  SHALL be high whenever state != IDLE.
REQ-017 jobs_done  out  16  SHALL count completed non-error jobs.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; the only legal transitions SHALL be IDLE->ISSUE, ISSUE->WAIT, WAIT->RESP and RESP->IDLE.
REQ-019 In IDLE, reqN_ready SHALL be high combinationally only for the granted requester; at most one ready SHALL be high per cycle, and none outside IDLE.
REQ-020 Arbitration SHALL be round-robin: if both requesters are valid, the grant goes to the requester not granted last; if only one is valid, it is granted.
REQ-021 After reset, last_grant=1, so req0 wins the first contention.
REQ-022 When valid & ready are both high, the arbiter SHALL register the operands and the owner id, update last_grant, and move to ISSUE.
REQ-023 In ISSUE, sa_valid_in SHALL be 1 for exactly one cycle, with sa_matrix_A/B driven from the operand registers; the state SHALL then move to WAIT.
REQ-024 sa_matrix_A/B SHALL hold the registered operands at all times and be 0 after reset.
REQ-025 On entering WAIT, the cycle counter SHALL clear; it increments by 1 each WAIT cycle.
REQ-026 sa_done is sticky high from a previous job, so it SHALL be ignored in the first WAIT cycle.
REQ-027 sa_done sampled high in any later WAIT cycle SHALL register sa_y into resp_y, clear resp_error, increment jobs_done and move to RESP.
REQ-028 If the counter reaches TIMEOUT_CYCLES with sa_done low, the arbiter SHALL move to RESP with resp_y=0, resp_error=1 and jobs_done unchanged.
REQ-029 If sa_done is high in the same cycle the counter reaches TIMEOUT_CYCLES, completion SHALL win.
REQ-030 In RESP, resp_valid=1 SHALL be asserted, with resp_y, resp_id and resp_error held stable until resp_ready is high.
REQ-031 A resp_ready high in the RESP cycle SHALL complete the handshake and return the state to IDLE.
REQ-032 resp_ready SHALL be ignored when resp_valid=0.
REQ-033 Latency from accept to resp_valid SHALL be 2 + k cycles, where k is the WAIT cycle in which sa_done is sampled (k >= 2).
REQ-034 A new job SHALL NOT be accepted in the cycle the response handshake completes; the earliest next accept is the following cycle.
REQ-035 jobs_done SHALL saturate at 16'hFFFF.
REQ-036 reqN_valid deasserting without a handshake SHALL leave the state unchanged.

Reset
REQ-037 Asserting reset SHALL immediately force state=IDLE, last_grant=1, counter=0 and jobs_done=0.
REQ-038 During reset, every output SHALL be 0: resp_valid, resp_error, resp_id, resp_y, sa_valid_in, sa_matrix_A/B, req0_ready, req1_ready and busy.
REQ-039 Reset mid-job SHALL discard the job with no response issued; the array is reset by the same reset signal.

Verification
REQ-040 Single job: req0 with A = identity (0x01000000_00010000_00000100_00000001) and B = all 8'h02 -> exactly one sa_valid_in pulse; resp_id=0, resp_error=0, every 32-bit word of resp_y = 2, jobs_done=1.
REQ-041 Contention: req0 and req1 valid together for 3 jobs each -> grant order 0,1,0,1,0,1; resp_id matches that order.
REQ-042 Backpressure: resp_ready held low 10 cycles -> resp_valid and resp_y stable for all 10 cycles; no new accept; IDLE one cycle after the handshake.
REQ-043 Timeout: sa_done tied 0, TIMEOUT_CYCLES=8 -> resp_error=1 and resp_y=0 after 8 WAIT cycles; jobs_done unchanged.
REQ-044 Stale done: sa_done already high at ISSUE and through the first WAIT cycle -> that cycle is ignored; the result is captured in the second WAIT cycle.
REQ-045 Reset asserted in WAIT -> all outputs 0 asynchronously; after release, a new req1 job is accepted and completes normally.
